// File: rtl/dnn_input_loader_if.sv
// Upstream sample stream into dnn_input_loader: activation words plus the
// per-sample ideal-output vector and etapos, which ride on the in_last word.
interface dnn_input_loader_if #(
   parameter int AW    = 512,
   parameter int N_OUT = 16,
   parameter int EW    = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [AW-1:0]    in_data;
   logic             in_last;
   logic [N_OUT-1:0] in_ans;
   logic [EW-1:0]    in_etapos;

   modport master (
      output in_valid, in_data, in_last, in_ans, in_etapos,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_data, in_last, in_ans, in_etapos,
      output in_ready
   );
endinterface

// File: rtl/dnn_input_loader.sv
// Ping-pong sample buffer feeding act0/ans0/etapos0 to the DNN in step with its
// block cycle; optional issue counters when DNN_LOADER_STATS_EN is defined.
module dnn_input_loader #(
   parameter  int width_in  = 8,
   parameter  int n0        = 1024,
   parameter  int z0        = 512,
   parameter  int fo0       = 8,
   parameter  int n_out     = 16,
   parameter  int z_out     = 1,
   parameter  int frac_bits = 7,
   localparam int AW        = width_in * z0 / fo0,
   localparam int NW        = n0 * fo0 / z0,
   localparam int CPC       = NW + 2,
   localparam int CW        = $clog2(CPC),
   localparam int EW        = $clog2(frac_bits + 2),
   localparam int WCW       = (NW > 1) ? $clog2(NW) : 1
) (
   input  logic                clk,
   input  logic                reset_n,
   dnn_input_loader_if.slave   in_bus,
   input  logic [CW-1:0]       cycle_index,
   output logic [AW-1:0]       act0,
   output logic [z_out-1:0]    ans0,
   output logic [EW-1:0]       etapos0,
   output logic                sample_live,
   output logic                proto_err
`ifdef DNN_LOADER_STATS_EN
   ,
   output logic [31:0]         samples_issued,
   output logic [31:0]         bubbles_issued
`endif
);

   localparam logic [EW-1:0] BUBBLE_ETA = EW'(frac_bits + 1);
   localparam int            AP         = (NW * z_out > n_out) ? NW * z_out : n_out;

   typedef enum logic [1:0] {
      BANK_EMPTY,
      BANK_FILLING,
      BANK_FULL,
      BANK_ACTIVE
   } bank_state_t;

   bank_state_t      bank_state     [2];
   bank_state_t      bank_state_nxt [2];
   logic             rd_sel;
   logic             rd_sel_nxt;
   logic             wr_sel;
   logic [WCW-1:0]   wr_cnt;
   logic [WCW-1:0]   wr_cnt_nxt;
   logic             proto_err_nxt;
   logic             live_nxt;

   logic [AW-1:0]    word_mem [2][NW];
   logic [n_out-1:0] ans_mem  [2];
   logic [EW-1:0]    eta_mem  [2];

   logic             accept;
   logic             last_word;
   logic             last_ok;
   logic             swap_edge;
   logic             swap_live;
   logic             word_slot;
   logic [AP-1:0]    ans_ext;

   // The write bank is always the one the read side is not holding.
   assign wr_sel    = ~rd_sel;
   assign in_bus.in_ready = reset_n &&
                            (bank_state[wr_sel] == BANK_EMPTY ||
                             bank_state[wr_sel] == BANK_FILLING);
   assign accept    = in_bus.in_valid && in_bus.in_ready;
   assign last_word = (wr_cnt == WCW'(NW - 1));
   assign last_ok   = (in_bus.in_last == last_word);
   assign swap_edge = (cycle_index == CW'(CPC - 1));
   assign swap_live = swap_edge && (bank_state[wr_sel] == BANK_FULL);
   assign word_slot = (cycle_index < CW'(NW));
   assign ans_ext   = AP'(ans_mem[rd_sel]);

   // Bank bookkeeping: the write side only touches wr_sel and the swap only
   // reads registered states, so a sample finishing on the swap edge waits.
   always_comb begin
      bank_state_nxt = bank_state;
      rd_sel_nxt     = rd_sel;
      wr_cnt_nxt     = wr_cnt;
      proto_err_nxt  = proto_err;
      live_nxt       = sample_live;

      if (accept) begin
         if (!last_ok) begin
            proto_err_nxt          = 1'b1;
            bank_state_nxt[wr_sel] = BANK_EMPTY;
            wr_cnt_nxt             = '0;
         end else if (last_word) begin
            bank_state_nxt[wr_sel] = BANK_FULL;
            wr_cnt_nxt             = '0;
         end else begin
            bank_state_nxt[wr_sel] = BANK_FILLING;
            wr_cnt_nxt             = wr_cnt + 1'b1;
         end
      end

      if (swap_edge) begin
         if (swap_live) begin
            bank_state_nxt[wr_sel] = BANK_ACTIVE;
            bank_state_nxt[rd_sel] = BANK_EMPTY;
            rd_sel_nxt             = wr_sel;
            live_nxt               = 1'b1;
         end else begin
            bank_state_nxt[rd_sel] = BANK_EMPTY;
            live_nxt               = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bank_state[0] <= BANK_EMPTY;
         bank_state[1] <= BANK_EMPTY;
         rd_sel        <= 1'b1;
         wr_cnt        <= '0;
         proto_err     <= 1'b0;
         sample_live   <= 1'b0;
      end else begin
         bank_state[0] <= bank_state_nxt[0];
         bank_state[1] <= bank_state_nxt[1];
         rd_sel        <= rd_sel_nxt;
         wr_cnt        <= wr_cnt_nxt;
         proto_err     <= proto_err_nxt;
         sample_live   <= live_nxt;
      end
   end

   // Sample storage needs no reset: bank state decides what is ever read.
   always_ff @(posedge clk) begin
      if (accept && last_ok) begin
         word_mem[wr_sel][wr_cnt] <= in_bus.in_data;
         if (last_word) begin
            ans_mem[wr_sel] <= in_bus.in_ans;
            eta_mem[wr_sel] <= in_bus.in_etapos;
         end
      end
   end

   // Outputs trail cycle_index by one clock; etapos0 only moves at the swap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         act0    <= '0;
         ans0    <= '0;
         etapos0 <= BUBBLE_ETA;
      end else begin
         if (sample_live && word_slot) begin
            act0 <= word_mem[rd_sel][cycle_index[WCW-1:0]];
            ans0 <= ans_ext[cycle_index[WCW-1:0] * z_out +: z_out];
         end else begin
            act0 <= '0;
            ans0 <= '0;
         end
         if (swap_edge) begin
            etapos0 <= swap_live ? eta_mem[wr_sel] : BUBBLE_ETA;
         end
      end
   end

`ifdef DNN_LOADER_STATS_EN
   // Saturating counts of live and bubble blocks, stepped at each swap edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         samples_issued <= '0;
         bubbles_issued <= '0;
      end else if (swap_edge) begin
         if (swap_live) begin
            if (samples_issued != '1) samples_issued <= samples_issued + 32'd1;
         end else begin
            if (bubbles_issued != '1) bubbles_issued <= bubbles_issued + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dnn_input_loader.sv
// Directed bench for dnn_input_loader in the small configuration (AW=128, NW=4,
// block cycle of 6); checks DNN_LOADER_STATS_EN counters when that macro is set.
module tb_dnn_input_loader;

   localparam int AW = 128;
   localparam int NW = 4;
   localparam int CPC = 6;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  cycle_index = 3'd0;
   logic [AW-1:0] act0;
   logic [0:0]  ans0;
   logic [3:0]  etapos0;
   logic        sample_live;
   logic        proto_err;
`ifdef DNN_LOADER_STATS_EN
   logic [31:0] samples_issued;
   logic [31:0] bubbles_issued;
   logic [31:0] samp_snap;
   logic [31:0] bub_snap;
`endif

   int n_cmp = 0;
   int n_err = 0;
   bit mon_en = 1'b0;
   logic [AW-1:0] obs_q[$];
   logic [3:0]    eta_q[$];
   int fc;
   int lc;

   dnn_input_loader_if #(.AW(AW), .N_OUT(4), .EW(4)) bus ();

   dnn_input_loader #(
      .width_in (8),
      .n0       (64),
      .z0       (32),
      .fo0      (2),
      .n_out    (4),
      .z_out    (1),
      .frac_bits(7)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_bus     (bus),
      .cycle_index(cycle_index),
      .act0       (act0),
      .ans0       (ans0),
      .etapos0    (etapos0),
      .sample_live(sample_live),
      .proto_err  (proto_err)
`ifdef DNN_LOADER_STATS_EN
      ,
      .samples_issued(samples_issued),
      .bubbles_issued(bubbles_issued)
`endif
   );

   always #5 clk = ~clk;

   // Stand-in for the DNN's free-running block-cycle counter.
   initial begin
      forever begin
         @(negedge clk);
         cycle_index = (cycle_index == 3'(CPC - 1)) ? 3'd0 : cycle_index + 3'd1;
      end
   end

   always begin
      @(posedge clk);
      #1;
      if (mon_en && sample_live && cycle_index < 3'(NW)) begin
         obs_q.push_back(act0);
         if (cycle_index == 3'd0) eta_q.push_back(etapos0);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [AW-1:0] word_of(input int s, input int w);
      logic [7:0] b;
      b = 8'(8'h11 * (w + 1) + 5 * (s - 1));
      return {16{b}};
   endfunction

   function automatic logic [3:0] ans_of(input int s);
      return 4'(4'b0001 << ((s + 1) % 4));
   endfunction

   function automatic logic [3:0] eta_of(input int s);
      return 4'((s + 2) % 8);
   endfunction

   task automatic check_output(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_word(input logic [AW-1:0] d, input logic last, input logic [3:0] ans,
                            input logic [3:0] eta, output int acc_c);
      int guard;
      guard = 0;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.in_last   = last;
      bus.in_ans    = ans;
      bus.in_etapos = eta;
      while (!bus.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      assert (bus.in_ready) else begin
         n_err++;
         $error("[TB] FAIL send_ready observed=0 expected=1 after %0d cycles", guard);
      end
      @(posedge clk);
      acc_c = int'(cycle_index);
   endtask

   task automatic apply_stimulus(input int s, input bit hold, output int first_c, output int last_c);
      int c;
      first_c = -1;
      last_c  = -1;
      for (int w = 0; w < NW; w++) begin
         send_word(word_of(s, w), (w == NW - 1), ans_of(s), eta_of(s), c);
         if (w == 0) first_c = c;
         last_c = c;
      end
      if (!hold) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic wait_block_start();
      int guard;
      guard = 0;
      do begin
         @(posedge clk);
         #1;
         guard++;
      end while (cycle_index != 3'd0 && guard < 20);
   endtask

   task automatic check_block(input int s, input bit live);
      logic [3:0] a;
      logic [AW-1:0] exp_act;
      logic exp_ans;
      a = ans_of(s);
      wait_block_start();
      for (int c = 0; c < CPC; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         exp_act = (live && c < NW) ? word_of(s, c) : '0;
         exp_ans = (live && c < NW) ? a[c] : 1'b0;
         check_output($sformatf("s%0d_c%0d_act0", s, c), act0, exp_act);
         check_output($sformatf("s%0d_c%0d_ans0", s, c), AW'(ans0), AW'(exp_ans));
         if (c < CPC - 1) begin
            check_output($sformatf("s%0d_c%0d_etapos0", s, c), AW'(etapos0),
                         AW'(live ? eta_of(s) : 4'd8));
            check_output($sformatf("s%0d_c%0d_live", s, c), AW'(sample_live), AW'(live));
         end
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.in_ans    = '0;
      bus.in_etapos = '0;

      $display("[TB] reset state");
      repeat (3) @(posedge clk);
      #1;
      check_output("rst_act0", act0, '0);
      check_output("rst_ans0", AW'(ans0), '0);
      check_output("rst_etapos0", AW'(etapos0), AW'(8));
      check_output("rst_live", AW'(sample_live), '0);
      check_output("rst_proto_err", AW'(proto_err), '0);
      check_output("rst_in_ready", AW'(bus.in_ready), '0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check_output("rel_in_ready", AW'(bus.in_ready), AW'(1));

      $display("[TB] single sample then bubble");
      wait_block_start();
`ifdef DNN_LOADER_STATS_EN
      samp_snap = samples_issued;
      bub_snap  = bubbles_issued;
`endif
      apply_stimulus(1, 1'b0, fc, lc);
      check_block(1, 1'b1);
`ifdef DNN_LOADER_STATS_EN
      check_output("stats_samples", AW'(samples_issued), AW'(samp_snap + 32'd1));
      check_output("stats_bubbles", AW'(bubbles_issued), AW'(bub_snap + 32'd1));
`endif
      check_block(0, 1'b0);

      $display("[TB] back-to-back samples");
      wait_block_start();
      obs_q.delete();
      eta_q.delete();
      mon_en = 1'b1;
      for (int s = 3; s <= 12; s++) begin
         apply_stimulus(s, 1'b1, fc, lc);
         #1;
         check_output($sformatf("b2b_s%0d_ready_low", s), AW'(bus.in_ready), '0);
         if (s > 3) check_output($sformatf("b2b_s%0d_first_c", s), AW'(fc), AW'(0));
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_block_start();
      wait_block_start();
      mon_en = 1'b0;
      check_output("b2b_word_count", AW'(obs_q.size()), AW'(40));
      check_output("b2b_eta_count", AW'(eta_q.size()), AW'(10));
      for (int s = 3; s <= 12; s++) begin
         check_output($sformatf("b2b_s%0d_eta", s), AW'(eta_q[s - 3]), AW'(eta_of(s)));
         for (int w = 0; w < NW; w++) begin
            check_output($sformatf("b2b_s%0d_w%0d", s, w), obs_q[(s - 3) * NW + w], word_of(s, w));
         end
      end

      $display("[TB] sample completing on the swap edge");
      wait_block_start();
      @(posedge clk);
      apply_stimulus(13, 1'b0, fc, lc);
      check_output("swap_edge_last_c", AW'(lc), AW'(5));
      check_block(13, 1'b0);
      check_block(13, 1'b1);

      $display("[TB] early in_last");
      wait_block_start();
      send_word(word_of(14, 0), 1'b0, ans_of(14), eta_of(14), lc);
      send_word(word_of(14, 1), 1'b0, ans_of(14), eta_of(14), lc);
      send_word(word_of(14, 2), 1'b1, ans_of(14), eta_of(14), lc);
      #1;
      check_output("proto_err_set", AW'(proto_err), AW'(1));
      check_output("proto_ready", AW'(bus.in_ready), AW'(1));
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_block_start();
      apply_stimulus(15, 1'b0, fc, lc);
      check_block(15, 1'b1);
      check_output("proto_err_sticky", AW'(proto_err), AW'(1));

      $display("[TB] reset mid-fill and mid-block");
      wait_block_start();
      apply_stimulus(16, 1'b0, fc, lc);
      wait_block_start();
      check_output("pre_rst_act0", act0, word_of(16, 0));
      send_word(word_of(2, 0), 1'b0, ans_of(2), eta_of(2), lc);
      send_word(word_of(2, 1), 1'b0, ans_of(2), eta_of(2), lc);
      @(negedge clk);
      reset_n = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check_output("mid_rst_act0", act0, '0);
      check_output("mid_rst_ans0", AW'(ans0), '0);
      check_output("mid_rst_etapos0", AW'(etapos0), AW'(8));
      check_output("mid_rst_live", AW'(sample_live), '0);
      check_output("mid_rst_proto_err", AW'(proto_err), '0);
      check_output("mid_rst_in_ready", AW'(bus.in_ready), '0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check_output("post_rst_in_ready", AW'(bus.in_ready), AW'(1));
      wait_block_start();
      apply_stimulus(2, 1'b0, fc, lc);
      check_block(2, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
